// File: rtl/scc_bus_initiator.sv
// scc_bus_initiator: queued bus master for the SCC register/wave-memory port.
// Commands enter a FIFO over cmd_valid/cmd_ready. Each one is replayed as a
// timed bus cycle: a 1-cycle request pulse, then ACTIVE_CYCLES of active
// strobe in total, then RECOVER_CYCLES idle cycles.
// Ports: clk, reset (async, active-high); cmd_* command port; rsp_* read data;
// busy; bus_* SCC-side strobes, address, write data and read data (bus_q).
// Optional: define SCC_BUS_INITIATOR_STATS_EN to add wr_count/rd_count.
module scc_bus_initiator #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int ACTIVE_CYCLES   = 4,
    parameter int RECOVER_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [14:0] cmd_address,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        bus_wrreq,
    output logic        bus_rdreq,
    output logic        bus_wr_active,
    output logic        bus_rd_active,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_q
`ifdef SCC_BUS_INITIATOR_STATS_EN
    ,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
`endif
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef struct packed {
        logic        write;
        logic [14:0] address;
        logic [7:0]  data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE,
        RECOVER
    } state_t;

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    cmd_t          tx;
    logic          last_active;

    assign cmd_ready   = (count != CW'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    // The head is only taken while idle, so a pop never sees a same-cycle push.
    assign pop         = (state == IDLE) && (count != '0);
    assign last_active = (state == ACTIVE) && (cnt == 4'd0);

    assign busy  = (count != '0) || (state != IDLE);
    assign bus_a = tx.address;
    assign bus_d = tx.data;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_address, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        state_nxt     = state;
        bus_wrreq     = 1'b0;
        bus_rdreq     = 1'b0;
        bus_wr_active = 1'b0;
        bus_rd_active = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus_wrreq     = tx.write;
                bus_rdreq     = !tx.write;
                bus_wr_active = tx.write;
                bus_rd_active = !tx.write;
                state_nxt     = ACTIVE;
            end
            ACTIVE: begin
                bus_wr_active = tx.write;
                bus_rd_active = !tx.write;
                if (cnt == 4'd0) begin
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // REQ is the first active cycle, hence the counter starts at ACTIVE_CYCLES-2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            tx        <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx <= mem[rd_ptr];
                    end
                end
                REQ: begin
                    cnt <= 4'(ACTIVE_CYCLES - 2);
                end
                ACTIVE: begin
                    if (cnt == 4'd0) begin
                        cnt <= 4'(RECOVER_CYCLES - 1);
                        if (!tx.write) begin
                            rsp_data  <= bus_q;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef SCC_BUS_INITIATOR_STATS_EN
    // Transactions are counted as they leave ACTIVE for RECOVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (last_active) begin
            if (tx.write) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
